// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard unit: load-use/RAW interlock, EX operand forwarding, branch flush, event counters
module pipe_hazard_ctrl #(
   parameter int AW       = 5,
   parameter int FWD_EN   = 1,
   parameter int BR_STAGE = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [AW-1:0]    id_dest,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             branch_taken,
   output logic             hold_if_id,
   output logic             flush_if_id,
   output logic             clear_id_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic          valid;
      logic          we;
      logic          mr;
      logic [AW-1:0] dest;
   } ent_t;

   ent_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [AW-1:0]    ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic             ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic use_rs, use_rt, ex_hit, mem_hit, stall_raw;

   // Register 0 is hard-wired, so it never counts as a pending write.
   function automatic logic writes(input ent_t e, input logic [AW-1:0] r);
      return e.valid & e.we & (e.dest == r) & (r != '0);
   endfunction

   always_comb begin
      use_rs    = id_valid & id_use_rs;
      use_rt    = id_valid & id_use_rt;
      ex_hit    = (use_rs & writes(ex_q, id_rs)) | (use_rt & writes(ex_q, id_rt));
      mem_hit   = (use_rs & writes(mem_q, id_rs)) | (use_rt & writes(mem_q, id_rt));
      stall_raw = (FWD_EN != 0) ? (ex_q.mr & ex_hit) : (ex_hit | mem_hit);

      hold_if_id  = 1'b0;
      flush_if_id = 1'b0;
      clear_id_ex = 1'b1;
      fwd_a       = 2'd0;
      fwd_b       = 2'd0;
      if (!clr) begin
         if (BR_STAGE == 2) begin
            // EX-resolved branch squashes the stalled ID instruction instead of holding it.
            flush_if_id = branch_taken;
            clear_id_ex = stall_raw | branch_taken;
            hold_if_id  = stall_raw & ~branch_taken;
         end else begin
            // ID branch operands are stale during a stall; the branch re-resolves afterwards.
            flush_if_id = branch_taken & ~stall_raw;
            clear_id_ex = stall_raw;
            hold_if_id  = stall_raw;
         end
         if (FWD_EN != 0) begin
            if (writes(mem_q, ex_rs_q))     fwd_a = 2'd1;
            else if (writes(wb_q, ex_rs_q)) fwd_a = 2'd2;
            if (writes(mem_q, ex_rt_q))     fwd_b = 2'd1;
            else if (writes(wb_q, ex_rt_q)) fwd_b = 2'd2;
         end
      end
   end

   always_comb begin
      ex_d        = '0;
      ex_rs_d     = '0;
      ex_rt_d     = '0;
      ex_use_rs_d = 1'b0;
      ex_use_rt_d = 1'b0;
      if (id_valid && !clear_id_ex) begin
         ex_d        = '{valid: 1'b1, we: id_reg_write, mr: id_mem_read, dest: id_dest};
         ex_rs_d     = id_rs;
         ex_rt_d     = id_rt;
         ex_use_rs_d = id_use_rs;
         ex_use_rt_d = id_use_rt;
      end
      mem_d = ex_q;
      wb_d  = mem_q;

      stall_cnt_d = stall_cnt_q;
      if (hold_if_id && !branch_taken && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (flush_if_id && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_use_rs_q <= 1'b0;
         ex_use_rt_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_use_rs_q <= ex_use_rs_d;
         ex_use_rt_q <= ex_use_rt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Source-use flags travel with EX for debug visibility; forwarding matches on address alone.
   logic ex_use_unused;
   assign ex_use_unused = ex_use_rs_q ^ ex_use_rt_q;

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- AW, 5: register-address width.
- FWD_EN, 1: 1 = forwarding plus load-use interlock; 0 = full interlock, no forwarding.
- BR_STAGE, 2: stage resolving branches; 1 = ID, 2 = EX.
- CNT_W, 16: event-counter width.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  ID source addresses.
- id_use_rs, id_use_rt  in  1  ID actually reads that source.
- id_dest  in  AW  ID destination, already resolved by reg_dest.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- branch_taken  in  1  taken branch/jump resolved in stage BR_STAGE.
- hold_if_id  out  1  freeze PC and IF_ID (drives reg_pipe hold).
- flush_if_id  out  1  clear IF_ID (drives reg_pipe clear).
- clear_id_ex  out  1  insert bubble into ID_EX (data and control).
- fwd_a, fwd_b  out  2  EX operand select: 0 = regfile/pipe, 1 = EX_MEM alu_result, 2 = MEM_WB write-back data.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Function
REQ-003 Block SHALL keep shadow entries EX, MEM and WB. Each entry holds {valid, we, mr, dest}; EX also holds {rs, rt, use_rs, use_rt}.
REQ-004 Every non-reset cycle: WB <= MEM, MEM <= EX. EX <= ID fields, or a bubble (valid=0) when clear_id_ex=1 or id_valid=0.
REQ-005 An entry "writes r" iff valid & we & dest==r & r!=0. Register 0 SHALL never cause a stall or a forward.
REQ-006 "Used" means the ID source has id_valid & id_use_* asserted.
REQ-007 FWD_EN=1, load-use: if EX.mr and EX writes a used ID source, then hold_if_id=1 and clear_id_ex=1 for exactly one cycle.
REQ-008 FWD_EN=1: fwd_a=1 if MEM writes EX.rs; else 2 if WB writes EX.rs; else 0. fwd_b is the same rule against EX.rt. MEM SHALL have priority over WB. fwd_* are combinational from shadow state.
REQ-009 FWD_EN=0: fwd_a=fwd_b=0 always. hold_if_id=clear_id_ex=1 while EX or MEM writes a used ID source; stall lasts 1-2 cycles.
REQ-010 WB writers SHALL never stall ID; the register file is write-through.
REQ-011 branch_taken=1 SHALL assert flush_if_id the same cycle.
REQ-012 If BR_STAGE=2, branch_taken SHALL also assert clear_id_ex.
REQ-013 BR_STAGE=1: branch_taken qualified by a pending stall SHALL be ignored until the stall ends. ID branch operands are not valid during a stall.
REQ-014 BR_STAGE=2: branch_taken SHALL override any stall the same cycle. hold_if_id=0; the stalled ID instruction is squashed.
REQ-015 stall_cnt SHALL increment on each cycle hold_if_id=1 and branch_taken=0.
REQ-016 flush_cnt SHALL increment on each cycle flush_if_id=1.
REQ-017 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 All outputs SHALL be glitch-free functions of registered state and current ID inputs. No combinational path from branch_taken to fwd_*.

Reset
REQ-019 clr=1 at a rising edge SHALL clear all shadow entries (valid=0) and both counters.
REQ-020 While clr=1: hold_if_id=0, flush_if_id=0, clear_id_ex=1, fwd_a=fwd_b=0.
REQ-021 clr asserted mid-stall SHALL abort the stall. No stall continues after clr deasserts.

Verification
REQ-022 FWD_EN=1: add r3 then sub r4,r3,r5 -> next cycle fwd_a=1; one cycle later fwd_a=0, no stall.
REQ-023 FWD_EN=1: lw r2 then add r6,r2,r2 -> one cycle with hold_if_id=clear_id_ex=1, then fwd_a=fwd_b=2; stall_cnt=1.
REQ-024 FWD_EN=0: add r3 then or r7,r3,r0 -> two stall cycles, fwd always 0; stall_cnt=2.
REQ-025 Any config: writer dest r0 followed by a reader of r0 -> no stall, fwd=0.
REQ-026 BR_STAGE=2: branch_taken coincident with a load-use stall -> flush_if_id=1, clear_id_ex=1, hold_if_id=0; flush_cnt=1, stall_cnt=0.
REQ-027 clr during a FWD_EN=0 stall, plus CNT_W=2 saturation check after 5 stalls -> outputs at reset values next cycle; stall_cnt holds at 3.
